// File: rtl/pika_risc.sv
// pika_risc: single-cycle 32-bit CPU for a subset of RV32I.
// One instruction is fetched, executed and retired on each rising clk edge.
// Instruction and data memories are external and combinational.
// Optional feature: define PIKA_RISC_MUL_EN to execute the R-type MUL
// encoding (f7=0000001, f3=000). Without the macro, that encoding is a NOP.
module pika_risc (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] dmem_addr,
  output logic        dmem_write_en,
  output logic [31:0] dmem_val_out,
  input  logic [31:0] dmem_val_in
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL
  } alu_op_t;

  typedef enum logic [2:0] {
    K_NOP, K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_LUI
  } kind_t;

  logic [31:0] pc;
  logic [31:0] regs [32];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  kind_t       kind;
  alu_op_t     alu_op;
  logic        alu_use_imm;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  logic [31:0] next_pc;
  logic        rd_we;
  logic [31:0] rd_data;

  assign instr   = imem_data;
  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign funct7  = instr[31:25];

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};

  // Control-flow targets are word aligned by clearing the two low bits.
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = (pc + imm_b) & 32'hFFFF_FFFC;
  assign jump_target   = (pc + imm_j) & 32'hFFFF_FFFC;

  assign imem_addr = {pc[31:2], 2'b00};

  // Decode the instruction class and ALU operation; anything unlisted is a NOP.
  always_comb begin
    kind        = K_NOP;
    alu_op      = ALU_ADD;
    alu_use_imm = 1'b0;
    case (opcode)
      OPC_R: begin
        kind = K_ALU;
        case ({funct7, funct3})
          10'b0000000_000: alu_op = ALU_ADD;
          10'b0100000_000: alu_op = ALU_SUB;
          10'b0000000_001: alu_op = ALU_SLL;
          10'b0000000_010: alu_op = ALU_SLT;
          10'b0000000_100: alu_op = ALU_XOR;
          10'b0000000_101: alu_op = ALU_SRL;
          10'b0100000_101: alu_op = ALU_SRA;
          10'b0000000_110: alu_op = ALU_OR;
          10'b0000000_111: alu_op = ALU_AND;
`ifdef PIKA_RISC_MUL_EN
          10'b0000001_000: alu_op = ALU_MUL;
`endif
          default:         kind   = K_NOP;
        endcase
      end
      OPC_I: begin
        kind        = K_ALU;
        alu_use_imm = 1'b1;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            if (funct7 == 7'b0000000) alu_op = ALU_SLL;
            else                      kind   = K_NOP;
          end
          3'b101: begin
            if (funct7 == 7'b0000000)      alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) alu_op = ALU_SRA;
            else                           kind   = K_NOP;
          end
          default: kind = K_NOP;
        endcase
      end
      OPC_LOAD:   if (funct3 == 3'b010) kind = K_LOAD;
      OPC_STORE:  if (funct3 == 3'b010) kind = K_STORE;
      OPC_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) kind = K_BRANCH;
      OPC_JAL:    kind = K_JAL;
      OPC_LUI:    kind = K_LUI;
      default:    kind = K_NOP;
    endcase
  end

  // Arithmetic/logic unit shared by R-type and I-ALU instructions.
  always_comb begin
    alu_b      = alu_use_imm ? imm_i : rs2_val;
    alu_result = 32'd0;
    case (alu_op)
      ALU_ADD: alu_result = rs1_val + alu_b;
      ALU_SUB: alu_result = rs1_val - alu_b;
      ALU_AND: alu_result = rs1_val & alu_b;
      ALU_OR:  alu_result = rs1_val | alu_b;
      ALU_XOR: alu_result = rs1_val ^ alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      ALU_SLL: alu_result = rs1_val << alu_b[4:0];
      ALU_SRL: alu_result = rs1_val >> alu_b[4:0];
      ALU_SRA: alu_result = $signed(rs1_val) >>> alu_b[4:0];
`ifdef PIKA_RISC_MUL_EN
      ALU_MUL: alu_result = rs1_val * alu_b;
`endif
      default: alu_result = 32'd0;
    endcase
  end

  // Execute: next PC, register write-back and data memory port; reset silences all side effects.
  always_comb begin
    next_pc       = pc_plus4;
    rd_we         = 1'b0;
    rd_data       = 32'd0;
    dmem_addr     = 32'd0;
    dmem_val_out  = 32'd0;
    dmem_write_en = 1'b0;
    case (kind)
      K_ALU: begin
        rd_we   = 1'b1;
        rd_data = alu_result;
      end
      K_LOAD: begin
        dmem_addr = rs1_val + imm_i;
        rd_we     = 1'b1;
        rd_data   = dmem_val_in;
      end
      K_STORE: begin
        dmem_addr     = rs1_val + imm_s;
        dmem_val_out  = rs2_val;
        dmem_write_en = 1'b1;
      end
      K_BRANCH: begin
        if ((rs1_val == rs2_val) != funct3[0]) next_pc = branch_target;
      end
      K_JAL: begin
        rd_we   = 1'b1;
        rd_data = pc_plus4;
        next_pc = jump_target;
      end
      K_LUI: begin
        rd_we   = 1'b1;
        rd_data = imm_u;
      end
      default: ;
    endcase
    if (reset) begin
      rd_we         = 1'b0;
      dmem_addr     = 32'd0;
      dmem_val_out  = 32'd0;
      dmem_write_en = 1'b0;
    end
  end

  // Architectural state: PC and register file, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (rd_we && rd != 5'd0) regs[rd] <= rd_data;
    end
  end

endmodule

// File: tb/tb_pika_risc.sv
// tb_pika_risc: scoreboard bench for pika_risc.
// An instruction-level reference model walks the program held in tb memory and
// queues the outputs expected in each cycle; a monitor compares them at negedge.
module tb_pika_risc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] dmem_addr;
  logic        dmem_write_en;
  logic [31:0] dmem_val_out;
  logic [31:0] dmem_val_in;

  pika_risc dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .dmem_addr     (dmem_addr),
    .dmem_write_en (dmem_write_en),
    .dmem_val_out  (dmem_val_out),
    .dmem_val_in   (dmem_val_in)
  );

  always #5 clk = ~clk;

  typedef enum int {
    T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_SLT, T_SLL, T_SRL, T_SRA, T_MUL,
    T_ADDI, T_ANDI, T_ORI, T_XORI, T_SLTI, T_SLLI, T_SRLI, T_SRAI,
    T_LW, T_SW, T_BEQ, T_BNE, T_JAL, T_LUI, T_BAD
  } op_t;

  typedef struct {
    op_t op;
    int  rd;
    int  rs1;
    int  rs2;
    int  imm;
  } instr_t;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  instr_t      prog [256];
  logic [31:0] imem [256];
  logic [31:0] dmem [64];

  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [64];
  logic [31:0] pend_npc;
  int          pend_rd;
  logic [31:0] pend_val;
  exp_t        pend_e;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Environment: combinational instruction/data memories, stores land on the rising edge.
  assign imem_data   = imem[imem_addr[9:2]];
  assign dmem_val_in = dmem[dmem_addr[7:2]];

  always @(posedge clk) begin
    if (dmem_write_en) dmem[dmem_addr[7:2]] <= dmem_val_out;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input instr_t in);
    logic [4:0]  d, s1, s2;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    d   = 5'(in.rd);
    s1  = 5'(in.rs1);
    s2  = 5'(in.rs2);
    i12 = 12'(in.imm);
    b13 = 13'(in.imm);
    j21 = 21'(in.imm);
    case (in.op)
      T_ADD:  return {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
      T_SUB:  return {7'b0100000, s2, s1, 3'b000, d, 7'b0110011};
      T_SLL:  return {7'b0000000, s2, s1, 3'b001, d, 7'b0110011};
      T_SLT:  return {7'b0000000, s2, s1, 3'b010, d, 7'b0110011};
      T_XOR:  return {7'b0000000, s2, s1, 3'b100, d, 7'b0110011};
      T_SRL:  return {7'b0000000, s2, s1, 3'b101, d, 7'b0110011};
      T_SRA:  return {7'b0100000, s2, s1, 3'b101, d, 7'b0110011};
      T_OR:   return {7'b0000000, s2, s1, 3'b110, d, 7'b0110011};
      T_AND:  return {7'b0000000, s2, s1, 3'b111, d, 7'b0110011};
      T_MUL:  return {7'b0000001, s2, s1, 3'b000, d, 7'b0110011};
      T_ADDI: return {i12, s1, 3'b000, d, 7'b0010011};
      T_SLTI: return {i12, s1, 3'b010, d, 7'b0010011};
      T_XORI: return {i12, s1, 3'b100, d, 7'b0010011};
      T_ORI:  return {i12, s1, 3'b110, d, 7'b0010011};
      T_ANDI: return {i12, s1, 3'b111, d, 7'b0010011};
      T_SLLI: return {7'b0000000, i12[4:0], s1, 3'b001, d, 7'b0010011};
      T_SRLI: return {7'b0000000, i12[4:0], s1, 3'b101, d, 7'b0010011};
      T_SRAI: return {7'b0100000, i12[4:0], s1, 3'b101, d, 7'b0010011};
      T_LW:   return {i12, s1, 3'b010, d, 7'b0000011};
      T_SW:   return {i12[11:5], s2, s1, 3'b010, i12[4:0], 7'b0100011};
      T_BEQ:  return {b13[12], b13[10:5], s2, s1, 3'b000, b13[4:1], b13[11], 7'b1100011};
      T_BNE:  return {b13[12], b13[10:5], s2, s1, 3'b001, b13[4:1], b13[11], 7'b1100011};
      T_JAL:  return {j21[20], j21[10:1], j21[11], j21[19:12], d, 7'b1101111};
      T_LUI:  return {20'(in.imm), d, 7'b0110111};
      default: begin
        // Encodings outside the supported set, selected by imm
        case (in.imm % 7)
          0:       return {7'b0000000, s2, s1, 3'b011, d, 7'b0110011};
          1:       return {7'b0000010, s2, s1, 3'b000, d, 7'b0110011};
          2:       return {12'h123, s1, 3'b011, d, 7'b0010011};
          3:       return {12'h008, s1, 3'b000, d, 7'b0000011};
          4:       return {7'b0000000, s2, s1, 3'b000, 5'd8, 7'b0100011};
          5:       return {7'b0000000, s2, s1, 3'b100, 5'd8, 7'b1100011};
          default: return {20'h12345, d, 7'b0010111};
        endcase
      end
    endcase
  endfunction

  function automatic instr_t mk(input op_t op, input int rd, input int rs1, input int rs2, input int imm);
    instr_t r;
    r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  task automatic loadProgram();
    for (int i = 0; i < 256; i++) imem[i] = encode(prog[i]);
  endtask

  task automatic clearProgram();
    for (int i = 0; i < 256; i++) prog[i] = mk(T_ADDI, 0, 0, 0, 0);
  endtask

  // Reference model: evaluate the instruction at m_pc, queue the expected outputs,
  // and hold the architectural effects until the clock edge commits them.
  task automatic applyStimulus(output exp_t e);
    instr_t      in;
    logic [31:0] a, b, imm, tgt;
    in       = prog[(m_pc / 4) % 256];
    a        = m_regs[in.rs1];
    b        = m_regs[in.rs2];
    imm      = 32'(in.imm);
    e.pc     = m_pc;
    e.we     = 1'b0;
    e.addr   = 32'd0;
    e.data   = 32'd0;
    pend_npc = m_pc + 32'd4;
    pend_rd  = 0;
    pend_val = 32'd0;
    tgt      = m_pc + imm;
    tgt      = tgt - (tgt % 4);
    case (in.op)
      T_ADD:  begin pend_rd = in.rd; pend_val = a + b; end
      T_SUB:  begin pend_rd = in.rd; pend_val = a - b; end
      T_AND:  begin pend_rd = in.rd; pend_val = a & b; end
      T_OR:   begin pend_rd = in.rd; pend_val = a | b; end
      T_XOR:  begin pend_rd = in.rd; pend_val = a ^ b; end
      T_SLT:  begin pend_rd = in.rd; pend_val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      T_SLL:  begin pend_rd = in.rd; pend_val = a << (b % 32); end
      T_SRL:  begin pend_rd = in.rd; pend_val = a >> (b % 32); end
      T_SRA:  begin pend_rd = in.rd; pend_val = $signed(a) >>> (b % 32); end
`ifdef PIKA_RISC_MUL_EN
      T_MUL:  begin pend_rd = in.rd; pend_val = a * b; end
`endif
      T_ADDI: begin pend_rd = in.rd; pend_val = a + imm; end
      T_ANDI: begin pend_rd = in.rd; pend_val = a & imm; end
      T_ORI:  begin pend_rd = in.rd; pend_val = a | imm; end
      T_XORI: begin pend_rd = in.rd; pend_val = a ^ imm; end
      T_SLTI: begin pend_rd = in.rd; pend_val = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; end
      T_SLLI: begin pend_rd = in.rd; pend_val = a << in.imm; end
      T_SRLI: begin pend_rd = in.rd; pend_val = a >> in.imm; end
      T_SRAI: begin pend_rd = in.rd; pend_val = $signed(a) >>> in.imm; end
      T_LW: begin
        e.addr   = a + imm;
        pend_rd  = in.rd;
        pend_val = m_mem[(e.addr / 4) % 64];
      end
      T_SW: begin
        e.we   = 1'b1;
        e.addr = a + imm;
        e.data = b;
      end
      T_BEQ:  if (a == b) pend_npc = tgt;
      T_BNE:  if (a != b) pend_npc = tgt;
      T_JAL:  begin pend_rd = in.rd; pend_val = m_pc + 32'd4; pend_npc = tgt; end
      T_LUI:  begin pend_rd = in.rd; pend_val = 32'(in.imm) * 32'd4096; end
      default: ;
    endcase
    pend_e = e;
    sb_q.push_back(e);
  endtask

  task automatic commitModel();
    if (pend_rd != 0) m_regs[pend_rd] = pend_val;
    if (pend_e.we) m_mem[(pend_e.addr / 4) % 64] = pend_e.data;
    m_pc = pend_npc;
  endtask

  // Assert reset away from a clock edge, check the outputs are silenced at once, hold across edges.
  task automatic assertReset(input exp_t aborted, input bit had_cycle);
    reset = 1'b1;
    sb_q.delete();
    #1;
    checkOutput("rst_imem_addr", imem_addr, 32'd0);
    checkOutput("rst_dmem_write_en", {31'd0, dmem_write_en}, 32'd0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
    checkOutput("rst_dmem_val_out", dmem_val_out, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    if (had_cycle && aborted.we)
      checkOutput("aborted_store", dmem[aborted.addr[7:2]], m_mem[(aborted.addr / 4) % 64]);
  endtask

  task automatic releaseReset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    reset = 1'b0;
  endtask

  task automatic runCycles(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      applyStimulus(e);
      @(posedge clk);
      commitModel();
      #1;
    end
  endtask

  // Monitor: pop and compare the expected outputs for every cycle executed out of reset.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("imem_addr", imem_addr, e.pc);
      checkOutput("dmem_write_en", {31'd0, dmem_write_en}, {31'd0, e.we});
      checkOutput("dmem_addr", dmem_addr, e.addr);
      checkOutput("dmem_val_out", dmem_val_out, e.data);
    end
  end

  function automatic instr_t randInstr();
    instr_t r;
    int     k;
    r.op  = op_t'($urandom_range(0, 24));
    r.rd  = int'($urandom_range(0, 7));
    r.rs1 = int'($urandom_range(0, 7));
    r.rs2 = int'($urandom_range(0, 7));
    case (r.op)
      T_SLLI, T_SRLI, T_SRAI: r.imm = int'($urandom_range(0, 31));
      T_LW, T_SW:             r.imm = int'($urandom_range(0, 255)) - 128;
      T_BEQ, T_BNE: begin
        k     = int'($urandom_range(0, 40)) - 20;
        r.imm = 2 * k;
      end
      T_JAL: begin
        k     = int'($urandom_range(0, 400)) - 200;
        r.imm = 2 * k;
      end
      T_LUI: r.imm = int'($urandom_range(0, 20'hFFFFF));
      T_BAD: r.imm = int'($urandom_range(0, 6));
      default: r.imm = int'($urandom_range(0, 4095)) - 2048;
    endcase
    return r;
  endfunction

  initial begin
    exp_t e;
    exp_t none;
    bit   aborted;
    none  = '{pc: 32'd0, we: 1'b0, addr: 32'd0, data: 32'd0};
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dmem[i]  = 32'd0;
      m_mem[i] = 32'd0;
    end

    // Directed program: ALU basics, branches, jumps, store/load, MUL, misaligned wrap jump.
    clearProgram();
    prog[0]   = mk(T_ADDI, 1, 0, 0, 5);
    prog[1]   = mk(T_ADDI, 2, 0, 0, -3);
    prog[2]   = mk(T_ADD,  3, 1, 2, 0);
    prog[3]   = mk(T_SLT,  4, 2, 1, 0);
    prog[4]   = mk(T_BNE,  0, 1, 1, 12);
    prog[5]   = mk(T_BEQ,  0, 1, 1, 12);
    prog[6]   = mk(T_JAL,  0, 0, 0, 16);
    prog[7]   = mk(T_ADDI, 0, 0, 0, 7);
    prog[8]   = mk(T_JAL,  6, 0, 0, -8);
    prog[10]  = mk(T_ADDI, 0, 0, 0, 7);
    prog[11]  = mk(T_SW,   0, 0, 1, 8);
    prog[12]  = mk(T_LW,   5, 0, 0, 8);
    prog[13]  = mk(T_MUL,  7, 1, 1, 0);
    for (int i = 0; i < 7; i++) prog[14 + i] = mk(T_SW, 0, 0, (i == 6) ? 0 : i + 2, 12 + 4 * i);
    prog[21]  = mk(T_JAL,  0, 0, 0, -86);
    prog[255] = mk(T_ADDI, 0, 0, 0, 0);
    loadProgram();

    #2;
    $display("[TB] reset and directed program");
    assertReset(none, 1'b0);
    releaseReset();
    runCycles(21);

    checkOutput("sw_x1", dmem[2], 32'd5);
    checkOutput("sw_x2", dmem[3], 32'hFFFF_FFFD);
    checkOutput("add_x3", dmem[4], 32'd2);
    checkOutput("slt_x4", dmem[5], 32'd1);
    checkOutput("lw_x5", dmem[6], 32'd5);
    checkOutput("jal_x6", dmem[7], 32'h24);
`ifdef PIKA_RISC_MUL_EN
    checkOutput("mul_x7", dmem[8], 32'd25);
`else
    checkOutput("mul_x7", dmem[8], 32'd0);
`endif
    checkOutput("x0_zero", dmem[9], 32'd0);

    // Second pass: abort the first store with reset; the sentinel must survive.
    $display("[TB] reset during store");
    dmem[2]  = 32'hDEAD_BEEF;
    m_mem[2] = 32'hDEAD_BEEF;
    aborted  = 1'b0;
    for (int c = 0; c < 30 && !aborted; c++) begin
      applyStimulus(e);
      if (e.we) begin
        #1;
        assertReset(e, 1'b1);
        aborted = 1'b1;
      end else begin
        @(posedge clk);
        commitModel();
        #1;
      end
    end
    checkOutput("abort_reached", {31'd0, aborted}, 32'd1);
    checkOutput("abort_sentinel", dmem[2], 32'hDEAD_BEEF);

    // Probe program: store every register to show the reset cleared them all.
    clearProgram();
    for (int i = 0; i < 32; i++) prog[i] = mk(T_SW, 0, 0, i, 4 * i);
    loadProgram();
    if (!aborted) assertReset(none, 1'b0);
    releaseReset();
    runCycles(34);

    // Random programs with random resets, some of them landing on stores.
    $display("[TB] random programs");
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) prog[i] = randInstr();
      assertReset(none, 1'b0);
      loadProgram();
      releaseReset();
      for (int c = 0; c < 800; c++) begin
        applyStimulus(e);
        if (($urandom % 150) == 0 || (e.we && ($urandom % 30) == 0)) begin
          #1;
          assertReset(e, 1'b1);
          releaseReset();
        end else begin
          @(posedge clk);
          commitModel();
          #1;
        end
      end
    end

    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
